// File: rtl/deserializador_pkg.sv
// Shared definitions for the serial-to-parallel front end and the downstream queue.
// Holds the handshake state encoding and the word width the queue also depends on.
// No ports; imported by deserializador, its interface and testbench.
package deserializador_pkg;

  // Word width shared with the queue (Fila); both sides must agree on it.
  localparam int WORD_WIDTH = 8;

  // Shallowest synchronizer that still gives metastability protection.
  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    READY   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/deserializador_if.sv
// Bundle of the serial input side and the queue-facing handshake of deserializador.
// Signals: data_in/write_in (serial bit + strobe), ack_in (queue-domain ack),
//          data_out/data_ready/status_out (assembled word, valid flag, collect/busy).
interface deserializador_if
  import deserializador_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
);

  logic             data_in;
  logic             write_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             status_out;

  // Environment: serial source plus queue-side acknowledge.
  modport master (
    output data_in,
    output write_in,
    output ack_in,
    input  data_out,
    input  data_ready,
    input  status_out
  );

  // The deserializer itself.
  modport slave (
    input  data_in,
    input  write_in,
    input  ack_in,
    output data_out,
    output data_ready,
    output status_out
  );

endinterface

// File: rtl/deserializador_sync_ff.sv
// sync_ff: STAGES-deep single-bit synchronizer into the clk_i domain.
// Ports: clk_i, rst_ni (async active-low, chain resets to 0), clr_i (synchronous
//        flush of the whole chain), d_i (asynchronous input), q_o (synchronized output).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else if (clr_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/deserializador.sv
// deserializador: shifts in one bit per accepted write_in strobe (first bit -> MSB),
// then offers the WIDTH-bit word to the queue with a four-phase ready/ack handshake.
// Ports: clock_100khz, reset (async active-low), bus (deserializador_if.slave).
module deserializador
  import deserializador_pkg::*;
#(
  parameter int WIDTH       = WORD_WIDTH,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic               clock_100khz,
  input  logic               reset,
  deserializador_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic accept;
  logic word_done;
  logic ack_sync;
  logic data_ready_c;
  logic status_c;

  // Bits are only taken while collecting; strobes during the handshake are dropped.
  assign accept    = (state_q == COLLECT) && bus.write_in;
  assign word_done = accept && (cnt_q == CNT_W'(WIDTH - 1));

  // The chain is flushed as the word completes, so an ack still held high from
  // before is re-timed through every stage and data_ready stays up for the full
  // SYNC_STAGES+1 cycles rather than dropping after one.
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i  (clock_100khz),
    .rst_ni (reset),
    .clr_i  (word_done),
    .d_i    (bus.ack_in),
    .q_o    (ack_sync)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock_100khz or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (word_done) state_d = READY;
      READY:   if (ack_sync)  state_d = RELEASE;
      // Ack must be seen low before new bits are taken, closing the four-phase cycle.
      RELEASE: if (!ack_sync) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
  end

  always_comb begin
    data_ready_c = (state_q == READY);
    status_c     = (state_q == COLLECT);
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (accept) begin
      shift_d = {shift_q[WIDTH-2:0], bus.data_in};
      if (word_done) begin
        word_d = {shift_q[WIDTH-2:0], bus.data_in};
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_100khz or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // data_out keeps the last word through the handshake and the next collect phase.
  assign bus.data_out   = word_q;
  assign bus.data_ready = data_ready_c;
  assign bus.status_out = status_c;

endmodule

// File: tb/tb_deserializador.sv
// Testbench for deserializador: directed scenarios plus random words with random
// strobe gaps and handshake-time noise; words are scored by an independent monitor.
// Ports: none.
module tb_deserializador;
  import deserializador_pkg::*;

  localparam int W  = WORD_WIDTH;
  localparam int SS = 2;

  logic clock_100khz = 1'b0;
  logic reset        = 1'b0;

  deserializador_if #(.WIDTH(W)) bus ();

  deserializador #(
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) dut (
    .clock_100khz (clock_100khz),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 clock_100khz = ~clock_100khz;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];
  logic         rdy_prev = 1'b0;
  logic [W-1:0] held_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every new data_ready pulse must carry the oldest expected word,
  // and data_out must not move while data_ready stays high.
  always @(negedge clock_100khz) begin
    if (reset && bus.data_ready && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word act=%0h exp=none at %0t", bus.data_out, $time);
      end else begin
        chk("word", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
      held_word = bus.data_out;
    end else if (reset && bus.data_ready && rdy_prev) begin
      chk("word_stable", 32'(bus.data_out), 32'(held_word));
    end
    rdy_prev = bus.data_ready;
  end

  // Model: the first bit sent lands in the MSB, so a complete word equals w itself.
  task automatic send_word(input logic [W-1:0] w, input int nbits,
                           input int mingap, input int maxgap, input bit check_lat);
    int gap;
    for (int i = 0; i < nbits; i++) begin
      bus.data_in  = w[W-1-i];
      bus.write_in = 1'b1;
      if (i == W - 1) exp_q.push_back(w);
      @(negedge clock_100khz);
      bus.write_in = 1'b0;
      if (i < nbits - 1) begin
        gap = $urandom_range(maxgap, mingap);
        repeat (gap) begin
          bus.data_in = 1'($urandom_range(1, 0));
          @(negedge clock_100khz);
        end
      end
      if (i == W - 2) chk("no_early_ready", 32'(bus.data_ready), 32'd0);
    end
    if (nbits == W && check_lat) begin
      chk("ready_latency", 32'(bus.data_ready), 32'd1);
      chk("status_busy", 32'(bus.status_out), 32'd0);
    end
  endtask

  task automatic noise(input bit en);
    if (en) begin
      bus.write_in = 1'($urandom_range(1, 0));
      bus.data_in  = 1'($urandom_range(1, 0));
    end
  endtask

  // Full four-phase handshake starting in READY; checks both SS+1 latencies.
  task automatic handshake(input bit en_noise);
    bus.ack_in = 1'b1;
    noise(en_noise);
    @(negedge clock_100khz); noise(en_noise);
    @(negedge clock_100khz);
    chk("ready_hold", 32'(bus.data_ready), 32'd1);
    noise(en_noise);
    @(negedge clock_100khz);
    chk("ready_fall", 32'(bus.data_ready), 32'd0);
    bus.ack_in = 1'b0;
    noise(en_noise);
    @(negedge clock_100khz); noise(en_noise);
    @(negedge clock_100khz);
    chk("status_hold", 32'(bus.status_out), 32'd0);
    noise(en_noise);
    @(negedge clock_100khz);
    chk("status_rise", 32'(bus.status_out), 32'd1);
    bus.write_in = 1'b0;
  endtask

  initial begin
    int n;
    bit done;
    logic [W-1:0] w;

    bus.data_in  = 1'b0;
    bus.write_in = 1'b0;
    bus.ack_in   = 1'b0;

    // Reset held with toggling inputs.
    repeat (6) begin
      @(negedge clock_100khz);
      bus.data_in  = 1'($urandom_range(1, 0));
      bus.write_in = 1'($urandom_range(1, 0));
      bus.ack_in   = 1'($urandom_range(1, 0));
    end
    chk("rst_data_out", 32'(bus.data_out), 32'h00);
    chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
    chk("rst_status", 32'(bus.status_out), 32'd1);
    bus.data_in  = 1'b0;
    bus.write_in = 1'b0;
    bus.ack_in   = 1'b0;
    @(negedge clock_100khz);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_100khz);
      chk("idle_outputs", 32'({bus.data_out, bus.data_ready, bus.status_out}), 32'({8'h00, 1'b0, 1'b1}));
    end

    // Basic word, back-to-back strobes.
    send_word(8'hA5, W, 0, 0, 1'b1);
    chk("basic_data", 32'(bus.data_out), 32'hA5);
    handshake(1'b0);
    chk("data_kept", 32'(bus.data_out), 32'hA5);

    // Gapped strobes of 1..5 idle cycles.
    send_word(8'hA5, W, 1, 5, 1'b1);
    handshake(1'b0);

    // Busy drop: strobes while READY and during the handshake are discarded.
    send_word(8'h5A, W, 0, 2, 1'b1);
    bus.write_in = 1'b1;
    bus.data_in  = 1'b1;
    repeat (10) @(negedge clock_100khz);
    bus.write_in = 1'b0;
    chk("busy_ready", 32'(bus.data_ready), 32'd1);
    chk("busy_data", 32'(bus.data_out), 32'h5A);
    handshake(1'b1);
    send_word(8'h3C, W, 0, 1, 1'b1);
    chk("after_drop_data", 32'(bus.data_out), 32'h3C);
    handshake(1'b0);

    // Reset mid-word discards the partial bits.
    send_word(8'hFF, 4, 0, 1, 1'b0);
    reset = 1'b0;
    @(negedge clock_100khz);
    chk("midrst_data_out", 32'(bus.data_out), 32'h00);
    chk("midrst_status", 32'(bus.status_out), 32'd1);
    @(negedge clock_100khz);
    reset = 1'b1;
    @(negedge clock_100khz);
    send_word(8'h0F, W, 0, 2, 1'b1);
    chk("midrst_word", 32'(bus.data_out), 32'h0F);
    handshake(1'b0);

    // Stale ack held high throughout collection.
    bus.ack_in = 1'b1;
    repeat (4) @(negedge clock_100khz);
    send_word(8'h81, W, 0, 1, 1'b1);
    n    = 1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clock_100khz);
      if (bus.data_ready) n++;
      else done = 1'b1;
    end
    chk("stale_ready_len", 32'(n), 32'(SS + 1));
    repeat (4) @(negedge clock_100khz);
    chk("stale_status_hold", 32'(bus.status_out), 32'd0);
    bus.ack_in = 1'b0;
    repeat (2) @(negedge clock_100khz);
    chk("stale_status_low", 32'(bus.status_out), 32'd0);
    @(negedge clock_100khz);
    chk("stale_status_rise", 32'(bus.status_out), 32'd1);

    // Random words, random gaps, random noise while busy.
    for (int k = 0; k < 30; k++) begin
      w = W'($urandom);
      send_word(w, W, 0, 3, 1'b1);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(4, 1)) begin
          noise(1'b1);
          @(negedge clock_100khz);
        end
        bus.write_in = 1'b0;
      end
      handshake(1'($urandom_range(1, 0)));
    end

    repeat (3) @(negedge clock_100khz);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
